// File: rtl/mem_bus_arbiter.sv
// Two-port strobe-bus arbiter in front of one single-port memory.
// Requests park in per-port slots; a round-robin FSM issues them one at a time.

module mem_bus_arbiter_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        rstrb,
  input  logic        clr,
  input  logic        cap,
  input  logic [31:0] mem_rdata,
  output logic        pend,
  output logic        is_wr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wmask,
  output logic [31:0] rdata,
  output logic        rbusy,
  output logic        wbusy
);
  logic acc;

  // Strobes arriving while the slot is occupied are dropped.
  assign acc = (rstrb | (|wmask)) & ~pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= 1'b0;
      is_wr   <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wmask <= '0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (acc) begin
      pend    <= 1'b1;
      is_wr   <= |wmask;
      s_addr  <= addr;
      s_wdata <= wdata;
      s_wmask <= wmask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rdata <= '0;
    else if (cap) rdata <= mem_rdata;
  end

  assign rbusy = pend & ~is_wr;
  assign wbusy = pend & is_wr;
endmodule

module mem_bus_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  input  logic        m0_rstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_rbusy,
  output logic        m0_wbusy,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  input  logic        m1_rstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_rbusy,
  output logic        m1_wbusy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata
);
  localparam int NP = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;

  logic [NP-1:0][31:0] p_addr, p_wdata, s_addr, s_wdata, p_rdata;
  logic [NP-1:0][3:0]  p_wmask, s_wmask;
  logic [NP-1:0]       p_rstrb, pend, is_wr, clr, cap, rbusy, wbusy;
  logic                gnt, gnt_sel, last_grant, done;
  logic [CNT_W-1:0]    cnt;

  assign p_addr  = {m1_addr,  m0_addr};
  assign p_wdata = {m1_wdata, m0_wdata};
  assign p_wmask = {m1_wmask, m0_wmask};
  assign p_rstrb = {m1_rstrb, m0_rstrb};

  for (genvar i = 0; i < NP; i++) begin : g_slot
    mem_bus_arbiter_slot u_slot (
      .clk(clk), .rst(rst),
      .addr(p_addr[i]), .wdata(p_wdata[i]), .wmask(p_wmask[i]), .rstrb(p_rstrb[i]),
      .clr(clr[i]), .cap(cap[i]), .mem_rdata(mem_rdata),
      .pend(pend[i]), .is_wr(is_wr[i]),
      .s_addr(s_addr[i]), .s_wdata(s_wdata[i]), .s_wmask(s_wmask[i]),
      .rdata(p_rdata[i]), .rbusy(rbusy[i]), .wbusy(wbusy[i])
    );
  end

  assign m0_rdata = p_rdata[0];
  assign m1_rdata = p_rdata[1];
  assign m0_rbusy = rbusy[0];
  assign m1_rbusy = rbusy[1];
  assign m0_wbusy = wbusy[0];
  assign m1_wbusy = wbusy[1];

  // Alternate only on contention; a lone requester always wins.
  assign gnt_sel = (&pend) ? ~last_grant : pend[1];
  assign done    = (state == WAIT) && (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|pend) state_nx = ISSUE;
      ISSUE:   state_nx = is_wr[gnt] ? IDLE : WAIT;
      WAIT:    if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    cap = '0;
    if ((state == ISSUE && is_wr[gnt]) || done) clr[gnt] = 1'b1;
    if (done) cap[gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      mem_rstrb  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|pend) begin
          gnt        <= gnt_sel;
          last_grant <= gnt_sel;
          mem_addr   <= s_addr[gnt_sel];
          mem_wdata  <= s_wdata[gnt_sel];
          mem_wmask  <= s_wmask[gnt_sel];
          mem_rstrb  <= ~is_wr[gnt_sel];
        end
        ISSUE: begin
          mem_wmask <= '0;
          mem_rstrb <= 1'b0;
          cnt       <= CNT_W'(RD_LATENCY);
        end
        WAIT:    cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed timing cases plus randomized two-port traffic,
// checked by a scoreboard against a plain byte-masked memory model.

module tb_mem_bus_arbiter;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wr;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [3:0]  m_wmask[2];
  logic        m_rstrb[2];
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, mem_rstrb;
  logic [3:0]  mem_wmask;

  int n_cmp = 0;
  int n_bad = 0;
  int rstrb_cnt = 0;
  acc_t        acc_q0[$], acc_q1[$];
  logic [31:0] rd_q0[$], rd_q1[$];
  int          grant_log[$];
  logic [31:0] hold[2];
  logic [1:0]  prev_rb;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] env_mem[logic [31:0]];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.RD_LATENCY(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_wmask(m_wmask[0]), .m0_rstrb(m_rstrb[0]),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_wmask(m_wmask[1]), .m1_rstrb(m_rstrb[1]),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wm[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : dflt(a);
  endfunction

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic rb(input int p);  return p != 0 ? m1_rbusy : m0_rbusy; endfunction
  function automatic logic wb(input int p);  return p != 0 ? m1_wbusy : m0_wbusy; endfunction
  function automatic logic [31:0] rd(input int p); return p != 0 ? m1_rdata : m0_rdata; endfunction

  function automatic logic acc_match(input acc_t e);
    if (e.addr !== mem_addr) return 1'b0;
    if (e.wr) return (mem_wmask === e.wmask) && (mem_wdata === e.wdata) && (mem_rstrb === 1'b0);
    return (mem_rstrb === 1'b1) && (mem_wmask === 4'h0);
  endfunction

  // Memory environment: byte-masked writes, reads return one cycle after mem_rstrb.
  initial forever begin
    @(posedge clk);
    if (mem_wmask != 4'h0) env_mem[mem_addr] = merge(env_rd(mem_addr), mem_wdata, mem_wmask);
    mem_rdata <= mem_rstrb ? env_rd(mem_addr) : $urandom;
  end

  // Scoreboard monitor: memory accesses and read completions.
  initial begin
    prev_rb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rb = '0;
        hold[0] = '0;
        hold[1] = '0;
      end else begin
        if (mem_rstrb || mem_wmask != 4'h0) begin
          acc_t e;
          int   p;
          if (mem_rstrb) rstrb_cnt++;
          p = -1;
          if (acc_q0.size() > 0 && acc_match(acc_q0[0])) p = 0;
          else if (acc_q1.size() > 0 && acc_match(acc_q1[0])) p = 1;
          if (p < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL mem_access: unexpected addr=%h wdata=%h wmask=%h rstrb=%b", mem_addr, mem_wdata, mem_wmask, mem_rstrb);
          end else begin
            e = (p == 0) ? acc_q0.pop_front() : acc_q1.pop_front();
            grant_log.push_back(p);
            check("mem_addr", mem_addr, e.addr);
          end
        end
        for (int p = 0; p < 2; p++) begin
          logic cur;
          cur = rb(p);
          if (prev_rb[p] && !cur) begin
            if ((p == 0 ? rd_q0.size() : rd_q1.size()) == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL rdata_done: port %0d completed a read nobody expected, rdata=%h", p, rd(p));
            end else begin
              hold[p] = (p == 0) ? rd_q0.pop_front() : rd_q1.pop_front();
              check(p == 0 ? "m0_rdata" : "m1_rdata", rd(p), hold[p]);
              check("other_rdata_held", rd(1 - p), hold[1 - p]);
            end
          end
          prev_rb[p] = cur;
        end
      end
    end
  end

  task automatic drive_req(input int p, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] wm, input bit rs_too, input int extra, input bit push_rd);
    int   n;
    acc_t e;
    n = 0;
    @(negedge clk);
    while ((rb(p) || wb(p)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_timeout: port %0d still busy after %0d cycles, expected idle", p, n);
      return;
    end
    e.addr = a; e.wdata = wd; e.wmask = wr ? wm : 4'h0; e.wr = wr;
    if (p == 0) acc_q0.push_back(e); else acc_q1.push_back(e);
    if (wr) ref_mem[a] = merge(ref_rd(a), wd, wm);
    else if (push_rd) begin
      if (p == 0) rd_q0.push_back(ref_rd(a)); else rd_q1.push_back(ref_rd(a));
    end
    m_addr[p] = a; m_wdata[p] = wd; m_wmask[p] = wr ? wm : 4'h0; m_rstrb[p] = wr ? rs_too : 1'b1;
    for (int k = 0; k <= extra; k++) begin
      @(negedge clk);
      m_addr[p] = $urandom; m_wdata[p] = $urandom; m_wmask[p] = 4'h0;
      m_rstrb[p] = (k < extra);
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((acc_q0.size() + acc_q1.size() + rd_q0.size() + rd_q1.size() != 0 ||
            m0_rbusy || m0_wbusy || m1_rbusy || m1_wbusy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_drain"}, acc_q0.size() + acc_q1.size() + rd_q0.size() + rd_q1.size()
          + m0_rbusy + m0_wbusy + m1_rbusy + m1_wbusy, 0);
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_rdata"}, {m0_rdata, m1_rdata}, 0);
    check({nm, "_busy"}, {m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}, 0);
    check({nm, "_mem_aw"}, {mem_addr, mem_wdata}, 0);
    check({nm, "_mem_strb"}, {mem_wmask, mem_rstrb}, 0);
  endtask

  task automatic rand_port(input int p, input logic [31:0] base, input int cnt);
    bit          wr;
    logic [31:0] a;
    logic [3:0]  wm;
    for (int i = 0; i < cnt; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = base + 32'(4 * $urandom_range(0, 7));
      wm = 4'($urandom_range(1, 15));
      drive_req(p, wr, a, $urandom, wm, 1'($urandom_range(0, 1)), $urandom_range(0, 1), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      m_addr[p] = '0; m_wdata[p] = '0; m_wmask[p] = '0; m_rstrb[p] = 1'b0;
    end
    hold[0] = '0;
    hold[1] = '0;
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Simultaneous reads: port 0 wins first, port 1 issued 3 cycles later.
    fork
      drive_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 0, 1'b1);
      drive_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 0, 1'b1);
    join
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      check("t2_rstrb", mem_rstrb, (c == 2 || c == 5));
      if (c == 2) check("t2_addr0", mem_addr, 32'h10);
      if (c == 5) check("t2_addr1", mem_addr, 32'h20);
      if (c >= 6) check("t2_m1_rbusy", m1_rbusy, c == 6);
    end
    check("t2_m0_rdata", m0_rdata, ref_rd(32'h10));
    check("t2_m1_rdata", m1_rdata, ref_rd(32'h20));
    drain("t2");

    // Continuous contention alternates the grant.
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++) drive_req(0, 1'b0, 32'h80 + 32'(i * 4), 32'h0, 4'h0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 4; i++) drive_req(1, 1'b0, 32'h1080 + 32'(i * 4), 32'h0, 4'h0, 1'b0, 0, 1'b1);
    join
    drain("t4");
    check("t4_grants", grant_log.size(), 8);
    for (int i = 0; i < 8; i++)
      check("t4_grant_order", (grant_log.size() > i) ? grant_log[i] : 9, i % 2);

    // Single read timing with a known word.
    ref_mem[32'h100] = 32'hDEADBEEF;
    env_mem[32'h100] = 32'hDEADBEEF;
    drive_req(0, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 0, 1'b1);
    check("t1_c1", {m0_rbusy, mem_rstrb}, 2'b10);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check("t1_rbusy", m0_rbusy, c <= 3);
      check("t1_rstrb", mem_rstrb, c == 2);
      if (c == 2) check("t1_addr", mem_addr, 32'h100);
    end
    check("t1_rdata", m0_rdata, 32'hDEADBEEF);
    drain("t1");

    // Port 1 write leaves its read data alone.
    drive_req(1, 1'b1, 32'h40, 32'h12345678, 4'b0011, 1'b0, 0, 1'b1);
    check("t3_wbusy_c1", m1_wbusy, 1'b1);
    @(negedge clk);
    check("t3_wmask", mem_wmask, 4'b0011);
    check("t3_addr_wdata", {mem_addr, mem_wdata}, {32'h40, 32'h12345678});
    check("t3_wbusy_c2", m1_wbusy, 1'b1);
    @(negedge clk);
    check("t3_wbusy_c3", m1_wbusy, 1'b0);
    check("t3_m1_rdata", m1_rdata, hold[1]);
    drain("t3");

    // Extra strobes while busy cause no extra memory access.
    rstrb_cnt = 0;
    drive_req(0, 1'b0, 32'h104, 32'h0, 4'h0, 1'b0, 2, 1'b1);
    drain("t5");
    check("t5_rstrb_count", rstrb_cnt, 1);

    fork
      rand_port(0, 32'h0000_0200, 40);
      rand_port(1, 32'h0000_1200, 40);
    join
    drain("rand");

    // Reset while a read waits for data.
    drive_req(0, 1'b0, 32'h108, 32'h0, 4'h0, 1'b0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("t6_rst");
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_dropped", m0_rdata, 0);
    drive_req(0, 1'b0, 32'h10C, 32'h0, 4'h0, 1'b0, 0, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      check("t6_rbusy", m0_rbusy, c <= 3);
    end
    check("t6_rdata", m0_rdata, ref_rd(32'h10C));
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
